// File: rtl/mcu_pkg.sv
// mcu_pkg: state, opcode, funct and select encodings shared by the
// multi-cycle MIPS sequencer, its datapath and the bench.
package mcu_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_EXEC_R   = 5'd2,
    S_WB_R     = 5'd3,
    S_EXEC_I   = 5'd4,
    S_WB_I     = 5'd5,
    S_MEM_ADDR = 5'd6,
    S_MEM_RD   = 5'd7,
    S_WB_LW    = 5'd8,
    S_MEM_WR   = 5'd9,
    S_BRANCH   = 5'd10,
    S_JUMP     = 5'd11,
    S_HALT     = 5'd12,
    S_ERROR    = 5'd13,
    S_INT_SAVE = 5'd14,
    S_INT_VEC  = 5'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_BREAK = 6'h0D;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_SLT   = 4'd4;
  localparam logic [3:0] ALU_PASSB = 4'd5;

  localparam logic [1:0] SB_B    = 2'd0;
  localparam logic [1:0] SB_4    = 2'd1;
  localparam logic [1:0] SB_IMM  = 2'd2;
  localparam logic [1:0] SB_IMM2 = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_VEC    = 2'd3;

  localparam logic [1:0] WS_RD_ALU = 2'd0;
  localparam logic [1:0] WS_RT_ALU = 2'd1;
  localparam logic [1:0] WS_RT_MDR = 2'd2;

  function automatic logic is_mem(state_e s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction

  function automatic logic [3:0] funct_alu(logic [5:0] f);
    logic [3:0] op;
    unique case (f)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mcu_mem_timer.sv
// mcu_mem_timer: counts non-ack cycles of one memory access and flags
// the cycle in which the wait reaches MEM_TIMEOUT (0 = never).
module mcu_mem_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start_i,
  input  logic busy_i,
  input  logic ack_i,
  output logic expired_o
);
  localparam int unsigned W =
    (MEM_TIMEOUT > 15) ? $clog2(MEM_TIMEOUT + 1) : 4;
  localparam logic [W-1:0] LIM =
    W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = '0;
    else if (busy_i && !ack_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // cnt_q holds waits already spent; this cycle's miss would be the last
  assign expired_o = (MEM_TIMEOUT != 0) && busy_i && !ack_i
                     && (cnt_q == LIM);

endmodule

// File: rtl/mcu_sequencer.sv
// mcu_sequencer: multi-cycle MIPS control sequencer, one micro-state per cycle.
// Define MCU_INTR_EN to enable interrupt entry at instruction boundaries.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  input  logic       intr,
  output logic       pc_ld,
  output logic       ir_ld,
  output logic       aluout_ld,
  output logic       mdr_ld,
  output logic       rf_we,
  output logic [1:0] rf_wsel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       mem_isel,
  output logic [3:0] alu_op,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic [1:0] pc_sel,
  output logic       halted,
  output logic       int_ack,
  output logic [4:0] state
);

  state_e state_q, state_d, boundary;
  logic   mem_busy, mem_start, expired;

  assign mem_busy  = is_mem(state_q);
  assign mem_start = !mem_busy || mem_ack;

  mcu_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (mem_start),
    .busy_i   (mem_busy),
    .ack_i    (mem_ack),
    .expired_o(expired)
  );

`ifdef MCU_INTR_EN
  assign boundary = intr ? S_INT_SAVE : S_FETCH;
`else
  assign boundary = S_FETCH;
  logic unused_intr;
  assign unused_intr = intr;
`endif

  function automatic state_e decode(logic [5:0] op, logic [5:0] fn);
    state_e s;
    logic   rt;
    s  = S_ERROR;
    rt = (op == OP_RTYPE);
    unique case (1'b1)
      rt && (fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT}):
        s = S_EXEC_R;
      rt && (fn == FN_BREAK):           s = S_HALT;
      (op == OP_LW) || (op == OP_SW):   s = S_MEM_ADDR;
      op == OP_BEQ:                     s = S_BRANCH;
      op == OP_J:                       s = S_JUMP;
      (op == OP_ADDI) || (op == OP_ORI): s = S_EXEC_I;
      default: ;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state_q <= S_FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:
        if (mem_ack)      state_d = S_DECODE;
        else if (expired) state_d = S_ERROR;
      S_DECODE:   state_d = decode(opcode, funct);
      S_EXEC_R:   state_d = S_WB_R;
      S_EXEC_I:   state_d = S_WB_I;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:
        if (mem_ack)      state_d = S_WB_LW;
        else if (expired) state_d = S_ERROR;
      S_MEM_WR:
        if (mem_ack)      state_d = boundary;
        else if (expired) state_d = S_ERROR;
      S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP:
        state_d = boundary;
`ifdef MCU_INTR_EN
      S_INT_SAVE: state_d = S_INT_VEC;
      S_INT_VEC:  state_d = S_FETCH;
`endif
      default: ;
    endcase
  end

  // Reset gates every output so in-flight strobes drop without a clock
  always_comb begin
    pc_ld     = 1'b0;
    ir_ld     = 1'b0;
    aluout_ld = 1'b0;
    mdr_ld    = 1'b0;
    rf_we     = 1'b0;
    rf_wsel   = WS_RD_ALU;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_isel  = 1'b0;
    alu_op    = ALU_ADD;
    alu_srca  = 1'b0;
    alu_srcb  = SB_B;
    pc_sel    = PC_ALU;
    int_ack   = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_rd   = 1'b1;
          mem_isel = 1'b1;
          alu_srcb = SB_4;
          ir_ld    = mem_ack;
          pc_ld    = mem_ack;
        end
        S_DECODE: begin
          alu_srcb  = SB_IMM2;
          aluout_ld = 1'b1;
        end
        S_EXEC_R: begin
          alu_srca  = 1'b1;
          alu_op    = funct_alu(funct);
          aluout_ld = 1'b1;
        end
        S_WB_R: rf_we = 1'b1;
        S_EXEC_I: begin
          alu_srca  = 1'b1;
          alu_srcb  = SB_IMM;
          alu_op    = (opcode == OP_ORI) ? ALU_OR : ALU_ADD;
          aluout_ld = 1'b1;
        end
        S_WB_I: begin
          rf_we   = 1'b1;
          rf_wsel = WS_RT_ALU;
        end
        S_MEM_ADDR: begin
          alu_srca  = 1'b1;
          alu_srcb  = SB_IMM;
          aluout_ld = 1'b1;
        end
        S_MEM_RD: begin
          mem_rd = 1'b1;
          mdr_ld = mem_ack;
        end
        S_WB_LW: begin
          rf_we   = 1'b1;
          rf_wsel = WS_RT_MDR;
        end
        S_MEM_WR: mem_wr = 1'b1;
        S_BRANCH: begin
          alu_srca = 1'b1;
          alu_op   = ALU_SUB;
          pc_ld    = zero;
          pc_sel   = PC_ALUOUT;
        end
        S_JUMP: begin
          pc_ld  = 1'b1;
          pc_sel = PC_JUMP;
        end
`ifdef MCU_INTR_EN
        S_INT_SAVE: aluout_ld = 1'b1;
        S_INT_VEC: begin
          pc_ld   = 1'b1;
          pc_sel  = PC_VEC;
          int_ack = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign halted = reset_n && (state_q inside {S_HALT, S_ERROR});
  assign state  = state_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// tb_mcu_sequencer: randomized instruction stream against a per-instruction
// model of cycle counts, strobe totals and selects.
module tb_mcu_sequencer;
  import mcu_pkg::*;

`ifdef MCU_INTR_EN
  localparam bit INTR_EN = 1'b1;
`else
  localparam bit INTR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       intr = 1'b0;
  logic       pc_ld, ir_ld, aluout_ld, mdr_ld, rf_we;
  logic [1:0] rf_wsel;
  logic       mem_rd, mem_wr, mem_isel;
  logic [3:0] alu_op;
  logic       alu_srca;
  logic [1:0] alu_srcb, pc_sel;
  logic       halted, int_ack;
  logic [4:0] state;

  mcu_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ack(mem_ack), .intr(intr),
    .pc_ld(pc_ld), .ir_ld(ir_ld), .aluout_ld(aluout_ld),
    .mdr_ld(mdr_ld), .rf_we(rf_we), .rf_wsel(rf_wsel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_isel(mem_isel),
    .alu_op(alu_op), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .pc_sel(pc_sel), .halted(halted), .int_ack(int_ack),
    .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cur = 0;

  typedef struct {
    int cyc, rd, wr, mdr, rf, wsel, aluld;
    int aop, bsel, pc, pcsel, isel;
    state_e fin;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s (instr %0d op=%h fn=%h): got %0d expected %0d",
               tag, cur, opcode, funct, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {11'd0, pc_ld, ir_ld, aluout_ld, mdr_ld, rf_we, mem_rd,
            mem_wr, mem_isel, int_ack, halted, alu_op, alu_srca,
            alu_srcb, pc_sel, rf_wsel};
  endfunction

  // Expected per-instruction totals straight from the instruction classes
  function automatic exp_t model(logic [5:0] op, logic [5:0] fn,
                                 logic z, int wf, int wm, logic irq);
    exp_t e;
    e.cyc = 2 + wf; e.rd = 1 + wf; e.isel = 1 + wf;
    e.wr = 0; e.mdr = 0; e.rf = 0; e.wsel = -1; e.aluld = 1;
    e.aop = -1; e.bsel = -1; e.pc = 1; e.pcsel = -1; e.fin = S_ERROR;
    case (op)
      OP_RTYPE:
        case (fn)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
            e.cyc = 4 + wf; e.rf = 1; e.wsel = 0; e.aluld = 2;
            e.bsel = 0; e.fin = S_FETCH;
            e.aop = (fn == FN_ADD) ? 0 : (fn == FN_SUB) ? 1 :
                    (fn == FN_AND) ? 2 : (fn == FN_OR) ? 3 : 4;
          end
          FN_BREAK: e.fin = S_HALT;
          default: ;
        endcase
      OP_ADDI, OP_ORI: begin
        e.cyc = 4 + wf; e.rf = 1; e.wsel = 1; e.aluld = 2;
        e.bsel = 2; e.aop = (op == OP_ORI) ? 3 : 0; e.fin = S_FETCH;
      end
      OP_LW: begin
        e.cyc = 5 + wf + wm; e.rd = 2 + wf + wm; e.mdr = 1;
        e.rf = 1; e.wsel = 2; e.aluld = 2; e.bsel = 2; e.aop = 0;
        e.fin = S_FETCH;
      end
      OP_SW: begin
        e.cyc = 4 + wf + wm; e.wr = 1 + wm; e.aluld = 2;
        e.bsel = 2; e.aop = 0; e.fin = S_FETCH;
      end
      OP_BEQ: begin
        e.cyc = 3 + wf; e.aop = 1; e.bsel = 0; e.pc = z ? 2 : 1;
        e.pcsel = z ? 1 : -1; e.fin = S_FETCH;
      end
      OP_J: begin
        e.cyc = 3 + wf; e.pc = 2; e.pcsel = 2; e.fin = S_FETCH;
      end
      default: ;
    endcase
    if (INTR_EN && irq && e.fin == S_FETCH) e.fin = S_INT_SAVE;
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("rst_outs", all_outs(), 0);
    chk("rst_state", state, S_FETCH);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic step(input logic a);
    @(negedge clk);
    mem_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int wf, input int wm);
    exp_t e;
    int n, wcnt, rd, wr, mdr, rf, wsel, aluld, aop, bsel;
    int pc, pcsel, isel, iack, pb;
    state_e st, prev, nst;
    cur++;
    opcode = op; funct = fn; zero = z;
    e = model(op, fn, z, wf, wm, intr);
    n = 0; wcnt = 0; rd = 0; wr = 0; mdr = 0; rf = 0; wsel = -1;
    aluld = 0; aop = -1; bsel = -1; pc = 0; pcsel = -1; isel = 0;
    iack = 0; pb = 0; prev = S_FETCH; nst = S_FETCH;
    while (n < 60) begin
      @(negedge clk);
      st = state_e'(state);
      if (n == 0 || st != prev) wcnt = 0;
      if (is_mem(st))
        mem_ack = (wcnt == ((st == S_FETCH) ? wf : wm));
      else
        mem_ack = 1'($urandom_range(0, 1));
      #1;
      rd += int'(mem_rd); wr += int'(mem_wr); mdr += int'(mdr_ld);
      rf += int'(rf_we); aluld += int'(aluout_ld); pc += int'(pc_ld);
      isel += int'(mem_isel); iack += int'(int_ack);
      if (rf_we) wsel = int'(rf_wsel);
      if (pc_ld && !ir_ld) pcsel = int'(pc_sel);
      if (alu_srca && aop < 0) begin
        aop = int'(alu_op);
        bsel = int'(alu_srcb);
      end
      if (alu_op == ALU_PASSB) pb++;
      wcnt++; prev = st; n++;
      @(posedge clk);
      #1;
      nst = state_e'(state);
      if ((nst == S_FETCH && st != S_FETCH) ||
          nst inside {S_HALT, S_ERROR, S_INT_SAVE}) break;
    end
    mem_ack = 1'b0;
    chk("cycles", n, e.cyc);
    chk("end_state", nst, e.fin);
    chk("mem_rd_cycles", rd, e.rd);
    chk("mem_isel_cycles", isel, e.isel);
    chk("mem_wr_cycles", wr, e.wr);
    chk("mdr_ld_pulses", mdr, e.mdr);
    chk("rf_we_pulses", rf, e.rf);
    chk("aluout_ld_pulses", aluld, e.aluld);
    chk("pc_ld_pulses", pc, e.pc);
    chk("int_ack_pulses", iack, 0);
    chk("passb_cycles", pb, 0);
    if (e.rf > 0) chk("rf_wsel", wsel, e.wsel);
    if (e.aop >= 0) begin
      chk("exec_alu_op", aop, e.aop);
      chk("exec_srcb", bsel, e.bsel);
    end
    if (e.pcsel >= 0) chk("pc_sel", pcsel, e.pcsel);
    if (e.fin == S_HALT || e.fin == S_ERROR) begin
      chk("halted", halted, 1);
      repeat (2) @(posedge clk);
      #1;
      chk("absorbing", state, e.fin);
      chk("halt_no_strobe", {mem_rd, mem_wr, pc_ld, rf_we}, 0);
      apply_reset();
    end
  endtask

  logic [5:0] fns [5];
  logic [5:0] op, fn;
  int n;

  initial begin
    fns = '{FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    apply_reset();

    // reset in the middle of a stalled load
    opcode = OP_LW;
    step(1'b1); step(1'b0); step(1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("mid_lw_state", state, S_MEM_RD);
    chk("mid_lw_rd", mem_rd, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_outs", all_outs(), 0);
    chk("async_rst_state", state, S_FETCH);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("post_rst_state", state, S_FETCH);
    chk("post_rst_halted", halted, 0);
    chk("post_rst_fetch_rd", mem_rd, 1);

    // unacked fetch times out
    apply_reset();
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      if (!mem_rd) break;
      n++;
      @(posedge clk);
    end
    chk("timeout_cycles", n, 15);
    chk("timeout_state", state, S_ERROR);
    chk("timeout_halted", halted, 1);

    // ack on the last allowed cycle wins
    apply_reset();
    opcode = OP_J;
    repeat (14) step(1'b0);
    step(1'b1);
    chk("ack_at_limit", state, S_DECODE);
    step(1'b0); step(1'b0);
    chk("ack_at_limit_done", state, S_FETCH);

    apply_reset();
    run_instr(OP_RTYPE, FN_ADD, 1'b0, 0, 0);
    run_instr(OP_LW, 6'h00, 1'b0, 0, 3);
    run_instr(OP_BEQ, 6'h00, 1'b1, 0, 0);
    run_instr(OP_BEQ, 6'h00, 1'b0, 1, 0);
    run_instr(OP_J, 6'h00, 1'b0, 2, 0);
    run_instr(OP_LW, 6'h00, 1'b0, 14, 14);
    run_instr(OP_SW, 6'h00, 1'b0, 0, 14);
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);
    run_instr(OP_RTYPE, FN_BREAK, 1'b0, 0, 0);
    run_instr(OP_RTYPE, 6'h3F, 1'b0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      op = 6'($urandom_range(0, 63));
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 8))
        0: begin op = OP_RTYPE; fn = fns[$urandom_range(0, 4)]; end
        1: op = OP_RTYPE;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        5: op = OP_J;
        6: op = OP_ADDI;
        7: op = OP_ORI;
        default: ;
      endcase
      intr = INTR_EN ? 1'b0 : 1'($urandom_range(0, 1));
      run_instr(op, fn, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 5));
    end
    intr = 1'b0;

`ifdef MCU_INTR_EN
    apply_reset();
    intr = 1'b1;
    run_instr(OP_SW, 6'h00, 1'b0, 0, 2);
    @(negedge clk);
    #1;
    chk("int_save_aluld", aluout_ld, 1);
    chk("int_save_nomem", {mem_rd, mem_wr, int_ack}, 0);
    @(posedge clk);
    #1;
    chk("int_vec_state", state, S_INT_VEC);
    @(negedge clk);
    #1;
    chk("int_vec_ack", int_ack, 1);
    chk("int_vec_pc", {pc_ld, pc_sel}, {1'b1, PC_VEC});
    @(posedge clk);
    #1;
    chk("int_ret_state", state, S_FETCH);
    intr = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
